apb_uart_bridge: RTL

APB_UART_BRIDGE -- requirements
Module: apb_uart_bridge

---
 rtl/apb_uart_bridge.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/apb_uart_bridge.sv
// apb_uart_bridge: APB slave that fronts a UART's TX/RX FIFOs and baud divisor.
// Register map: 0x0 DATA (push TX / pop RX), 0x4 STATUS, 0x8 BAUD.
// Optional feature: define APB_UART_PSLVERR_EN to answer unmapped or
// misaligned accesses with pslverr=1 (otherwise they read 0, writes dropped).
module apb_uart_bridge #(
  parameter logic [10:0] BAUD_RESET = 11'd650
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        tx_fifo_writeEn,
  output logic [7:0]  tx_fifo_dataIn,
  input  logic        tx_fifo_full,
  input  logic        tx_fifo_empty,
  output logic        rx_fifo_readEn,
  input  logic [7:0]  rx_fifo_dataOut,
  input  logic        rx_fifo_empty,
  input  logic        rx_fifo_full,
  output logic [10:0] baud_final_value
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_BAUD   = 4'h8;

  state_t      state, state_next;
  logic [10:0] baud_q;
  logic        tx_ovf_q, rx_unf_q;
  logic        ovf_set, ovf_clr, unf_set, unf_clr, baud_we;

  // Upper write-data bits have no destination in this register map.
  logic unused_pwdata;
  assign unused_pwdata = ^pwdata[31:11];

  logic sel_data, sel_status, sel_baud, addr_ok, access, rd_pop;
  assign sel_data   = (paddr == ADDR_DATA);
  assign sel_status = (paddr == ADDR_STATUS);
  assign sel_baud   = (paddr == ADDR_BAUD);
  assign addr_ok    = sel_data | sel_status | sel_baud;
  // A genuine access phase: setup already seen, master still selecting us.
  assign access     = (state == ACCESS) && psel && penable && !reset;
  // Only a DATA read with bytes waiting needs the extra cycle for the pop.
  assign rd_pop     = access && !pwrite && sel_data && !rx_fifo_empty;

  assign baud_final_value = baud_q;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create ordering races.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, APB response, FIFO strobes and register update requests.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next      = state;
    pready          = 1'b0;
    pslverr         = 1'b0;
    prdata          = 32'd0;
    tx_fifo_writeEn = 1'b0;
    tx_fifo_dataIn  = 8'd0;
    rx_fifo_readEn  = 1'b0;
    ovf_set         = 1'b0;
    ovf_clr         = 1'b0;
    unf_set         = 1'b0;
    unf_clr         = 1'b0;
    baud_we         = 1'b0;
    case (state)
      IDLE: begin
        // An access phase without a preceding setup phase is ignored.
        if (psel && !penable) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = IDLE;
        if (rd_pop) begin
          rx_fifo_readEn = 1'b1;
          state_next     = RD_WAIT;
        end else if (access) begin
          pready = 1'b1;
          if (!addr_ok) begin
`ifdef APB_UART_PSLVERR_EN
            pslverr = 1'b1;
`else
            pslverr = 1'b0;
`endif
          end else if (pwrite) begin
            if (sel_data) begin
              if (tx_fifo_full) begin
                ovf_set = 1'b1;
              end else begin
                tx_fifo_writeEn = 1'b1;
                tx_fifo_dataIn  = pwdata[7:0];
              end
            end
            if (sel_status) begin
              ovf_clr = pwdata[4];
              unf_clr = pwdata[5];
            end
            if (sel_baud) baud_we = 1'b1;
          end else begin
            if (sel_data) unf_set = 1'b1;  // empty RX: read 0, flag underflow
            if (sel_status)
              prdata = {26'd0, rx_unf_q, tx_ovf_q, tx_fifo_full,
                        tx_fifo_empty, rx_fifo_full, rx_fifo_empty};
            if (sel_baud) prdata = {21'd0, baud_q};
          end
        end
      end
      RD_WAIT: begin
        // Popped byte is now at the FIFO head; finish the wait-stated read.
        state_next = IDLE;
        if (psel && !reset) begin
          pready = 1'b1;
          prdata = {24'd0, rx_fifo_dataOut};
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // BAUD register and sticky error flags; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q   <= BAUD_RESET;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      if (baud_we) baud_q <= pwdata[10:0];
      if (ovf_set)      tx_ovf_q <= 1'b1;
      else if (ovf_clr) tx_ovf_q <= 1'b0;
      if (unf_set)      rx_unf_q <= 1'b1;
      else if (unf_clr) rx_unf_q <= 1'b0;
    end
  end

endmodule
